// File: rtl/muldiv_pkg.sv
// Shared definitions for the sequential multiply/divide unit: op encodings,
// FSM state type and the iteration-counter width helper.
package muldiv_pkg;

    localparam logic [1:0] OP_MULU = 2'b00;
    localparam logic [1:0] OP_MULS = 2'b01;
    localparam logic [1:0] OP_DIVU = 2'b10;
    localparam logic [1:0] OP_DIVS = 2'b11;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StFix
    } state_t;

    // Counter must hold the value WIDTH itself, hence the extra bit.
    function automatic int unsigned cnt_width(input int unsigned width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/muldiv_abs.sv
// Conditional two's-complement: passes the value through or negates it.
// Serves both operand magnitude extraction and signed result correction.
module muldiv_abs #(
    parameter int unsigned WIDTH = 16
) (
    input  logic [WIDTH-1:0] value,
    input  logic             negate,
    output logic [WIDTH-1:0] result
);

    always_comb begin
        result = negate ? (~value + {{(WIDTH-1){1'b0}}, 1'b1}) : value;
    end

endmodule

// File: rtl/muldiv_seq.sv
// Sequential signed/unsigned multiply (WxW->2W) and restoring divide (2W/W).
// Optional MULDIV_EARLY_EXIT_EN: multiply stops once the remaining multiplier is zero.
module muldiv_seq
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic [1:0]         op,
    input  logic [2*WIDTH-1:0] opa,
    input  logic [WIDTH-1:0]   opb,
    output logic               ready,
    output logic               done,
    output logic [WIDTH-1:0]   res_hi,
    output logic [WIDTH-1:0]   res_lo,
    output logic               flag_n,
    output logic               flag_z,
    output logic               flag_dz,
    output logic               flag_ovf
);

    localparam int unsigned CW = cnt_width(WIDTH);
    localparam int unsigned W2 = 2 * WIDTH;
    localparam logic [WIDTH-1:0] POS_LIM = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] NEG_LIM = {1'b1, {(WIDTH-1){1'b0}}};

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [1:0]       op_q;
    logic             neg_res;
    logic             rem_neg;
    logic             dz;
    logic             ovf;
    logic [W2-1:0]    acc;
    logic [W2-1:0]    mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] divisor;

    // Operand magnitudes, computed from the live inputs at accept time.
    logic [W2-1:0]    a_in;
    logic [W2-1:0]    a_mag;
    logic [WIDTH-1:0] b_mag;
    logic             a_sign;
    logic             b_sign;
    logic             div_zero;
    logic             div_big;

    always_comb begin
        a_in     = op[1] ? opa : {{WIDTH{op[0] & opa[WIDTH-1]}}, opa[WIDTH-1:0]};
        a_sign   = op[0] & a_in[W2-1];
        b_sign   = op[0] & opb[WIDTH-1];
        div_zero = (opb == '0);
        div_big  = (a_mag[W2-1:WIDTH] >= b_mag);
    end

    muldiv_abs #(.WIDTH(W2)) u_abs_a (
        .value  (a_in),
        .negate (a_sign),
        .result (a_mag)
    );

    muldiv_abs #(.WIDTH(WIDTH)) u_abs_b (
        .value  (opb),
        .negate (b_sign),
        .result (b_mag)
    );

    // One iteration of each datapath.
    logic [WIDTH:0]   win;
    logic [WIDTH+1:0] diff;
    logic [W2-1:0]    div_next;
    logic [W2-1:0]    mul_next;
    logic [WIDTH-1:0] mplier_next;
    logic [CW-1:0]    cnt_next;
    logic             run_exit;

    always_comb begin
        // Partial remainder stays below the divisor, so the W+1-bit window is
        // always under twice the divisor and a successful difference fits in W bits.
        win         = {acc[W2-1:WIDTH], acc[WIDTH-1]};
        diff        = {1'b0, win} - {2'b00, divisor};
        div_next    = diff[WIDTH+1] ? {acc[W2-2:0], 1'b0}
                                    : {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        mul_next    = mplier[0] ? (acc + mcand) : acc;
        mplier_next = mplier >> 1;
        cnt_next    = cnt - CW'(1);
`ifdef MULDIV_EARLY_EXIT_EN
        run_exit    = (cnt_next == '0) || (!op_q[1] && (mplier_next == '0));
`else
        run_exit    = (cnt_next == '0);
`endif
    end

    // Result correction in FIX.
    logic [W2-1:0]    fix_in;
    logic [W2-1:0]    fix_res;
    logic [WIDTH-1:0] fix_rem;
    logic             sdiv_ovf;

    always_comb begin
        fix_in   = op_q[1] ? {{WIDTH{1'b0}}, acc[WIDTH-1:0]} : acc;
        sdiv_ovf = (op_q == OP_DIVS) &&
                   (neg_res ? (acc[WIDTH-1:0] > NEG_LIM) : (acc[WIDTH-1:0] > POS_LIM));
    end

    muldiv_abs #(.WIDTH(W2)) u_abs_res (
        .value  (fix_in),
        .negate (neg_res),
        .result (fix_res)
    );

    muldiv_abs #(.WIDTH(WIDTH)) u_abs_rem (
        .value  (acc[W2-1:WIDTH]),
        .negate (rem_neg),
        .result (fix_rem)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= StIdle;
            cnt      <= '0;
            op_q     <= '0;
            neg_res  <= 1'b0;
            rem_neg  <= 1'b0;
            dz       <= 1'b0;
            ovf      <= 1'b0;
            acc      <= '0;
            mcand    <= '0;
            mplier   <= '0;
            divisor  <= '0;
            ready    <= 1'b1;
            done     <= 1'b0;
            res_hi   <= '0;
            res_lo   <= '0;
            flag_n   <= 1'b0;
            flag_z   <= 1'b0;
            flag_dz  <= 1'b0;
            flag_ovf <= 1'b0;
        end else begin
            unique case (state)
                StIdle: begin
                    done <= 1'b0;
                    if (start && ready) begin
                        op_q     <= op;
                        neg_res  <= a_sign ^ b_sign;
                        rem_neg  <= op[1] & a_sign;
                        dz       <= 1'b0;
                        ovf      <= 1'b0;
                        ready    <= 1'b0;
                        cnt      <= CW'(WIDTH);
                        flag_n   <= 1'b0;
                        flag_z   <= 1'b0;
                        flag_dz  <= 1'b0;
                        flag_ovf <= 1'b0;
                        if (op[1]) begin
                            acc     <= a_mag;
                            divisor <= b_mag;
                            if (div_zero) begin
                                dz    <= 1'b1;
                                state <= StFix;
                            end else if (div_big) begin
                                ovf   <= 1'b1;
                                state <= StFix;
                            end else begin
                                state <= StRun;
                            end
                        end else begin
                            acc    <= '0;
                            mcand  <= {{WIDTH{1'b0}}, a_mag[WIDTH-1:0]};
                            mplier <= b_mag;
                            state  <= StRun;
                        end
                    end
                end
                StRun: begin
                    cnt <= cnt_next;
                    if (op_q[1]) begin
                        acc <= div_next;
                    end else begin
                        acc    <= mul_next;
                        mcand  <= mcand << 1;
                        mplier <= mplier_next;
                    end
                    if (run_exit) begin
                        state <= StFix;
                    end
                end
                StFix: begin
                    done  <= 1'b1;
                    ready <= 1'b1;
                    state <= StIdle;
                    if (dz || ovf || sdiv_ovf) begin
                        res_hi   <= '0;
                        res_lo   <= '0;
                        flag_n   <= 1'b0;
                        flag_z   <= 1'b0;
                        flag_dz  <= dz;
                        flag_ovf <= ovf | sdiv_ovf;
                    end else if (op_q[1]) begin
                        res_hi <= fix_rem;
                        res_lo <= fix_res[WIDTH-1:0];
                        flag_n <= fix_res[WIDTH-1];
                        flag_z <= (fix_res[WIDTH-1:0] == '0);
                    end else begin
                        res_hi <= fix_res[W2-1:WIDTH];
                        res_lo <= fix_res[WIDTH-1:0];
                        flag_n <= fix_res[W2-1];
                        flag_z <= (fix_res == '0);
                    end
                end
                default: begin
                    state <= StIdle;
                    ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed self-checking bench for muldiv_seq at WIDTH=16.
// Latency expectations follow MULDIV_EARLY_EXIT_EN when it is defined.
module tb_muldiv_seq;

    localparam int unsigned W = 16;

`ifdef MULDIV_EARLY_EXIT_EN
    localparam int LAT_MULS = 4;   // |multiplier| = 5
    localparam int LAT_MUL0 = 14;  // multiplier 0x1234
    localparam int LAT_EE   = 3;   // multiplier 3
`else
    localparam int LAT_MULS = 17;
    localparam int LAT_MUL0 = 17;
    localparam int LAT_EE   = 17;
`endif

    logic           clk = 1'b0;
    logic           reset_n = 1'b0;
    logic           start = 1'b0;
    logic [1:0]     op = 2'b00;
    logic [2*W-1:0] opa = '0;
    logic [W-1:0]   opb = '0;
    logic           ready;
    logic           done;
    logic [W-1:0]   res_hi;
    logic [W-1:0]   res_lo;
    logic           flag_n;
    logic           flag_z;
    logic           flag_dz;
    logic           flag_ovf;

    int tests = 0;
    int fails = 0;
    int lat;
    int pulses;

    muldiv_seq #(.WIDTH(W)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .op       (op),
        .opa      (opa),
        .opb      (opb),
        .ready    (ready),
        .done     (done),
        .res_hi   (res_hi),
        .res_lo   (res_lo),
        .flag_n   (flag_n),
        .flag_z   (flag_z),
        .flag_dz  (flag_dz),
        .flag_ovf (flag_ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [1:0] o, input logic [2*W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        op    = o;
        opa   = a;
        opb   = b;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // lat = number of edges after the accept edge until done is seen high.
    task automatic wait_done(input int from, output int n);
        n = from;
        while (!done && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic run(input logic [1:0] o, input logic [2*W-1:0] a, input logic [W-1:0] b,
                       output int n);
        issue(o, a, b);
        wait_done(0, n);
    endtask

    // {dz, ovf, n, z}
    function automatic logic [3:0] flags();
        return {flag_dz, flag_ovf, flag_n, flag_z};
    endfunction

    initial begin
        #12;
        check("reset_outputs", {ready, done, res_hi, res_lo, flags()}, {2'b10, 32'h0, 4'h0});
        @(negedge clk);
        reset_n = 1'b1;

        run(2'b00, 32'h0000_FFFF, 16'hFFFF, lat);
        check("mulu_lat", 64'(lat), 64'(17));
        check("mulu_res", {res_hi, res_lo}, 32'hFFFE_0001);
        check("mulu_flags", flags(), 4'b0010);
        check("mulu_ready", ready, 1'b1);

        run(2'b01, 32'h0000_FFFD, 16'h0005, lat);
        check("muls_lat", 64'(lat), 64'(LAT_MULS));
        check("muls_res", {res_hi, res_lo}, 32'hFFFF_FFF1);
        check("muls_flags", flags(), 4'b0010);

        run(2'b11, 32'hFFFF_FFF9, 16'h0002, lat);
        check("divs_lat", 64'(lat), 64'(17));
        check("divs_q_r", {res_hi, res_lo}, {16'hFFFF, 16'hFFFD});
        check("divs_flags", flags(), 4'b0010);

        run(2'b11, 32'h0000_0007, 16'hFFFE, lat);
        check("divs_negdivisor", {res_hi, res_lo}, {16'h0001, 16'hFFFD});

        run(2'b10, 32'h0001_2345, 16'h0100, lat);
        check("divu_q_r", {res_hi, res_lo}, {16'h0045, 16'h0123});
        check("divu_flags", flags(), 4'b0000);

        run(2'b10, 32'h0000_1234, 16'h0000, lat);
        check("dz_lat", 64'(lat), 64'(1));
        check("dz_res", {res_hi, res_lo}, 32'h0);
        check("dz_flags", flags(), 4'b1000);

        run(2'b10, 32'h0001_0000, 16'h0001, lat);
        check("ovfu_lat", 64'(lat), 64'(1));
        check("ovfu_res", {res_hi, res_lo}, 32'h0);
        check("ovfu_flags", flags(), 4'b0100);

        run(2'b11, 32'h0000_8000, 16'h0001, lat);
        check("ovfs_pos_lat", 64'(lat), 64'(17));
        check("ovfs_pos", {res_hi, res_lo, flags()}, {32'h0, 4'b0100});

        run(2'b11, 32'hFFFF_8000, 16'h0001, lat);
        check("ovfs_neg_ok", {res_hi, res_lo, flags()}, {16'h0000, 16'h8000, 4'b0010});

        run(2'b00, 32'h0000_0000, 16'h1234, lat);
        check("mul_zero_lat", 64'(lat), 64'(LAT_MUL0));
        check("mul_zero", {res_hi, res_lo, flags()}, {32'h0, 4'b0001});

        run(2'b00, 32'h0000_1234, 16'h0003, lat);
        check("ee_lat", 64'(lat), 64'(LAT_EE));
        check("ee_res", {res_hi, res_lo}, 32'h0000_369C);

        // A start pulse during RUN is ignored and not queued.
        issue(2'b00, 32'h0000_0003, 16'h8004);
        repeat (3) @(posedge clk);
        @(negedge clk);
        op    = 2'b10;
        opa   = 32'h0000_0064;
        opb   = 16'h0005;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("busy_ready", ready, 1'b0);
        wait_done(4, lat);
        check("busy_lat", 64'(lat), 64'(17));
        check("busy_res", {res_hi, res_lo}, 32'h0001_800C);
        pulses = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (done) pulses++;
        end
        check("busy_not_queued", 64'(pulses), 64'(0));

        // Asynchronous reset during a multiply aborts it.
        issue(2'b00, 32'h0000_FFFF, 16'hFFFF);
        repeat (2) @(posedge clk);
        @(negedge clk);
        start = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        start   = 1'b0;
        reset_n = 1'b0;
        #1;
        check("abort_outputs", {ready, done, res_hi, res_lo, flags()}, {2'b10, 32'h0, 4'h0});
        @(negedge clk);
        reset_n = 1'b1;
        pulses  = 0;
        repeat (25) begin
            @(posedge clk);
            #1;
            if (done) pulses++;
        end
        check("abort_no_done", 64'(pulses), 64'(0));
        check("abort_idle", {ready, res_hi, res_lo}, {1'b1, 32'h0});

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
- Parametrised sequential multiply/divide unit for the CPU execution stage; serves MUL and DIV instructions through a start/ready/done handshake.
- Multiply: WIDTH x WIDTH into a 2*WIDTH product.
- Divide: 2*WIDTH dividend by WIDTH divisor into a WIDTH quotient and WIDTH remainder.
- Both operations run signed or unsigned. Divide-by-zero, quotient overflow and N/Z result flags are reported for condition-code update.

Parameters:
- WIDTH, 16, operand width in bits (allowed 8..64); the iteration counter is $clog2(WIDTH)+1 bits.

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only while ready=1.
- op  in  2  operation: 00 unsigned mul, 01 signed mul, 10 unsigned div, 11 signed div.
- opa  in  2*WIDTH  dividend (div); mul uses opa[WIDTH-1:0] as multiplicand.
- opb  in  WIDTH  multiplier (mul) or divisor (div).
- ready  out  1  idle and able to accept start.
- done  out  1  one-cycle pulse; results and flags are valid from this cycle.
- res_hi  out  WIDTH  mul: product[2W-1:W]; div: remainder.
- res_lo  out  WIDTH  mul: product[W-1:0]; div: quotient.
- flag_n  out  1  mul: product MSB; div: quotient MSB.
- flag_z  out  1  mul: product==0; div: quotient==0.
- flag_dz  out  1  divide by zero.
- flag_ovf  out  1  quotient does not fit in WIDTH bits (signed or unsigned range as selected).

Behaviour:
- Reset (asynchronous, any state): state=IDLE, ready=1, done=0, all results and flags 0, counter 0. Reset mid-operation aborts with no done pulse.
- States: IDLE -> RUN -> FIX -> IDLE.
- IDLE:
  - Accept when start&ready. Latch op. For signed ops, latch operand magnitudes and negative_result = sign(a)^sign(b); for signed div also latch rem_neg = sign(dividend).
  - Go to RUN with counter=WIDTH. ready drops in the cycle after accept.
- Div short-circuit (decided in IDLE on accept):
  - divisor==0: flag_dz=1, go directly to FIX.
  - |dividend|[2W-1:W] >= |divisor|: flag_ovf=1, go directly to FIX.
- RUN, mul: one shift-add per cycle. If multiplier LSB=1, acc += multiplicand_shifted. Shift multiplier right, multiplicand left, counter-1.
- RUN, div: restoring shift-subtract per cycle, remainder-window style (a 2W quotient/remainder register against a fixed W+1-bit divisor). Borrow clear: take the difference and shift in 1. Borrow set: shift in 0.
- Leave RUN when the counter reaches 0, i.e. after exactly WIDTH RUN cycles.
- FIX (one cycle):
  - Apply two's-complement correction to the magnitude result: product or quotient if negative_result, remainder if rem_neg.
  - Signed div range check: quotient magnitude > 2^(W-1)-1 when positive, or > 2^(W-1) when negative -> flag_ovf=1.
  - Register res_hi/res_lo/flags, pulse done, return to IDLE (ready=1 in the same cycle as done).
- Latency: accept edge E. Normal ops: done high in the cycle after edge E+WIDTH+1. Short-circuited div: done in the cycle after edge E+1.
- On dz/ovf: res_hi=res_lo=0, flag_n=flag_z=0; the other error flag stays 0.
- Signed div semantics: truncate toward zero; remainder takes the dividend's sign.
- Flags and results hold from done until the next accepted start. On accept, all flags clear.
- start while busy is ignored and not queued. start held high continuously re-triggers on each return to IDLE.
- Operand inputs are only sampled at accept; they may change during RUN.

Optional Feature:
- MULDIV_EARLY_EXIT_EN: multiply leaves RUN as soon as the post-shift multiplier is zero. RUN cycles = max(1, index of highest set bit of |multiplier| + 1). Divide latency is unchanged.
- Without the macro: fixed WIDTH RUN cycles for every op.

Decomposition:
- Package muldiv_pkg holds:
  - op encodings OP_MULU/OP_MULS/OP_DIVU/OP_DIVS;
  - state enum (IDLE, RUN, FIX);
  - localparam helper for counter width.
- One sub-module, muldiv_abs (parametrised width): conditional two's-complement. Used for operand magnitude and result correction.

Test Plan (WIDTH=16):
- Unsigned mul 0xFFFF*0xFFFF -> res_hi=0xFFFE, res_lo=0x0001, flag_n=1, done in the cycle after edge E+17.
- Signed mul -3*5 -> {res_hi,res_lo}=0xFFFFFFF1, flag_n=1, flag_z=0.
- Signed div 0xFFFFFFF9 / 0x0002 -> quotient 0xFFFD, remainder 0xFFFF, flag_n=1.
- Divide by zero, then overflow:
  - opa=0x00001234, opb=0 -> flag_dz=1, results 0, done in the cycle after edge E+1.
  - Unsigned 0x00010000 / 1 -> flag_ovf=1 (short-circuit).
- Signed boundary:
  - 0x00008000 / 1 -> flag_ovf=1.
  - 0xFFFF8000 / 1 -> quotient 0x8000, flag_ovf=0.
- reset_n low at RUN cycle 7 of a mul, start asserted while busy -> no done pulse, outputs 0, ready=1. The busy start is ignored. With MULDIV_EARLY_EXIT_EN, 0x1234*0x0003 -> 2 RUN cycles, result 0x0000369C.
